// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// and the per-operation iteration count.
package mdu_pkg;

  localparam int ITER = 32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mdu_datapath.sv
// One combinational iteration: shift-add (multiply) or restoring trial-subtract (divide),
// plus sign correction of the step's result for the final HI/LO write.
module mdu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         i_op,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opb,
  input  logic               i_neg_q,
  input  logic               i_neg_r,
  output logic [2*WIDTH-1:0] o_next_acc,
  output logic [WIDTH-1:0]   o_res_hi,
  output logic [WIDTH-1:0]   o_res_lo
);
  import mdu_pkg::*;

  logic               w_is_div;
  logic [WIDTH:0]     w_add_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_is_div  = (i_op == OP_DIV) || (i_op == OP_DIVU);
    // Multiply: acc = {partial product, remaining multiplier bits}, LSB gates the add.
    w_add_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opb} : {(WIDTH+1){1'b0}});
    // Divide: acc = {remainder, dividend/quotient}; shift one dividend bit into the remainder.
    w_trial   = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff    = w_trial - {1'b0, i_opb};

    if (w_is_div) begin
      if (w_diff[WIDTH])
        o_next_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      else
        o_next_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_next_acc = {w_add_sum, i_acc[WIDTH-1:1]};
    end

    w_prod = i_neg_q ? -o_next_acc : o_next_acc;
    w_quot = i_neg_q ? -o_next_acc[WIDTH-1:0] : o_next_acc[WIDTH-1:0];
    w_rem  = i_neg_r ? -o_next_acc[2*WIDTH-1:WIDTH] : o_next_acc[2*WIDTH-1:WIDTH];

    o_res_hi = w_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
    o_res_lo = w_is_div ? w_quot : w_prod[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: 32-cycle iterative ops, done pulses the cycle after the
// last iteration; the controller stalls on busy and start/hilo_we are ignored while running.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = mdu_pkg::ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  import mdu_pkg::*;

  localparam int CW = $clog2(ITER);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mag_b;
  logic [1:0]         r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_div0;
  logic [2*WIDTH-1:0] w_next_acc;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  always_comb begin
    w_signed = (op == OP_MULT) || (op == OP_DIV);
    w_is_div = !((op == OP_MULT) || (op == OP_MULTU));
    w_a_neg  = w_signed && srcA[WIDTH-1];
    w_b_neg  = w_signed && srcB[WIDTH-1];
    w_mag_a  = w_a_neg ? -srcA : srcA;
    w_mag_b  = w_b_neg ? -srcB : srcB;
    w_div0   = w_is_div && (srcB == '0);
  end

  mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .i_op       (r_op),
    .i_acc      (r_acc),
    .i_opb      (r_mag_b),
    .i_neg_q    (r_neg_q),
    .i_neg_r    (r_neg_r),
    .o_next_acc (w_next_acc),
    .o_res_hi   (w_res_hi),
    .o_res_lo   (w_res_lo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_acc   <= '0;
      r_mag_b <= '0;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_next_acc;
      r_count <= r_count + 1'b1;
      if (r_count == CW'(ITER - 1)) begin
        r_hi    <= w_res_hi;
        r_lo    <= w_res_lo;
        r_state <= DONE;
      end
    end else if (start) begin
      // A simultaneous hilo_we is dropped: the operation owns HI/LO from here.
      r_op    <= op;
      r_count <= '0;
      r_mag_b <= w_mag_b;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
      if (w_div0) begin
        r_hi    <= srcA;
        r_lo    <= '1;
        r_state <= DONE;
      end else begin
        r_state <= RUN;
      end
    end else begin
      r_state <= IDLE;
      if (hilo_we) begin
        if (hilo_sel) r_hi <= hilo_wdata;
        else          r_lo <= hilo_wdata;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .srcA       (srcA),
    .srcB       (srcB),
    .hilo_we    (hilo_we),
    .hilo_sel   (hilo_sel),
    .hilo_wdata (hilo_wdata),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference: plain 64-bit / integer arithmetic with the MIPS corner cases.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    int          ia;
    int          ib;
    longint      sp;
    logic [63:0] up;
    ia = a;
    ib = b;
    if (o[1] && b == 32'h0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else if (o == 2'd0) begin
      sp = longint'(ia) * longint'(ib);
      up = sp;
      eh = up[63:32];
      el = up[31:0];
    end else if (o == 2'd1) begin
      up = {32'h0, a} * {32'h0, b};
      eh = up[63:32];
      el = up[31:0];
    end else if (o == 2'd2) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        el = 32'h8000_0000;
        eh = 32'h0;
      end else begin
        el = ia / ib;
        eh = ia % ib;
      end
    end else begin
      el = a / b;
      eh = a % b;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is expected high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic we, input int poke);
    logic [31:0] eh;
    logic [31:0] el;
    model(o, a, b, eh, el);
    start = 1'b1; op = o; srcA = a; srcB = b;
    hilo_we = we; hilo_sel = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
    step();
    start = 1'b0; hilo_we = 1'b0;
    if (!(o[1] && b == 32'h0)) begin
      for (int c = 1; c <= 32; c++) begin
        check("busy_run", busy, 1'b1);
        check("done_run", done, 1'b0);
        check("hi_hold", hi, m_hi);
        check("lo_hold", lo, m_lo);
        if (c == poke) begin
          start = 1'b1; op = 2'd3; srcA = 32'd9; srcB = 32'd3;
          hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hA5A5_A5A5;
        end
        step();
        start = 1'b0; hilo_we = 1'b0;
      end
    end
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("hi_result", hi, eh);
    check("lo_result", lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic idle_check();
    step();
    check("done_gone", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("hi_idle", hi, m_hi);
    check("lo_idle", lo, m_lo);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1; start = 1'b0; op = 2'd0; srcA = '0; srcB = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    idle_check();
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, -1);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);
    idle_check();
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, -1);
    check("divu_lo", lo, 32'd14);
    idle_check();
    run_op(2'd3, 32'h64, 32'h0, 1'b0, -1);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    idle_check();
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    idle_check();
    run_op(2'd2, 32'hFFFF_FF00, 32'h0, 1'b0, -1);

    // Direct writes in IDLE.
    idle_check();
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hA5A5_A5A5;
    step();
    hilo_we = 1'b0;
    m_hi = 32'hA5A5_A5A5;
    check("dw_hi", hi, m_hi);
    check("dw_lo_keep", lo, m_lo);
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h1234_5678;
    step();
    hilo_we = 1'b0;
    m_lo = 32'h1234_5678;
    check("dw_lo", lo, m_lo);
    check("dw_hi_keep", hi, m_hi);

    // start+hilo_we together drops the write; start+write mid-run are ignored.
    run_op(2'd1, 32'd5, 32'd6, 1'b1, 10);
    check("ignored_start_lo", lo, 32'd30);
    idle_check();

    // Reset mid-operation aborts it.
    start = 1'b1; op = 2'd1; srcA = 32'd5; srcB = 32'd6;
    step();
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      check("abort_busy", busy, 1'b1);
      if (c == 10) begin
        start = 1'b1; op = 2'd3; srcA = 32'd9; srcB = 32'd3;
      end
      step();
      start = 1'b0;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy0", busy, 1'b0);
    check("abort_done0", done, 1'b0);
    idle_check();
    run_op(2'd1, 32'd5, 32'd6, 1'b0, -1);
    check("after_rst_lo", lo, 32'd30);
    check("after_rst_hi", hi, 32'd0);

    // Random ops, sometimes back-to-back from DONE.
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
